// File: rtl/addsub_chunked.sv
// Multi-cycle adder/subtractor: K result bits per clock, LSB chunk first, with
// optional signed saturation applied when the last chunk is written.
module addsub_chunked #(
  parameter int unsigned W = 8,
  parameter int unsigned K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         M,
  input  logic         SAT,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] S,
  output logic         C,
  output logic         V
);

  localparam int unsigned N    = W / K;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, s_q, s_d;
  logic           m_q, m_d, sat_q, sat_d, c_q, c_d, v_q, v_d;

  logic [31:0]  shamt;
  logic [K-1:0] a_chunk, b_chunk;
  logic [K:0]   chunk_sum;
  logic [W-1:0] chunk_mask, s_merged, sat_val;
  logic         last_chunk, ovf, accept;

  always_comb begin
    shamt      = 32'(cnt_q) * K;
    a_chunk    = K'(a_q >> shamt);
    b_chunk    = K'(b_q >> shamt) ^ {K{m_q}};
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + (K+1)'(carry_q);
    chunk_mask = W'({K{1'b1}}) << shamt;
    s_merged   = (s_q & ~chunk_mask) | (W'(chunk_sum[K-1:0]) << shamt);
    last_chunk = (cnt_q == CntW'(N - 1));
    // Operands of equal sign whose sum flips sign: same as carry-in ^ carry-out at the MSB.
    ovf        = (a_q[W-1] == (b_q[W-1] ^ m_q)) && (chunk_sum[K-1] != a_q[W-1]);
    sat_val    = a_q[W-1] ? (W'(1) << (W - 1)) : ~(W'(1) << (W - 1));
    accept     = start && (state_q != StRun);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    sat_d   = sat_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;

    unique case (state_q)
      StIdle: state_d = StIdle;
      StDone: state_d = StIdle;
      StRun: begin
        s_d     = s_merged;
        carry_d = chunk_sum[K];
        cnt_d   = cnt_q + 1'b1;
        if (last_chunk) begin
          c_d     = chunk_sum[K];
          v_d     = ovf;
          state_d = StDone;
          if (sat_q && ovf) s_d = sat_val;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      a_d     = A;
      b_d     = B;
      m_d     = M;
      sat_d   = SAT;
      cnt_d   = '0;
      carry_d = M;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      sat_q   <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      sat_q   <= sat_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign ready = (state_q != StRun);
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign S     = s_q;
  assign C     = c_q;
  assign V     = v_q;

endmodule

// File: tb/tb_addsub_chunked.sv
// Randomised and directed checks of addsub_chunked against a signed-arithmetic
// reference model; extra instances cover other W/K combinations.
module tb_addsub_chunked;

  logic       clk = 1'b0;
  logic       rst, start, m, sat;
  logic [7:0] a, b;
  logic       ready, busy, done, c, v;
  logic [7:0] s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  addsub_chunked #(.W(8), .K(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .M(m), .SAT(sat),
    .ready(ready), .busy(busy), .done(done), .S(s), .C(c), .V(v)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Works on the signed values directly: overflow is "true result out of range".
  function automatic void model(input int w, input longint unsigned ai, input longint unsigned bi,
                                input bit mi, input bit si, output longint unsigned es,
                                output bit ec, output bit ev);
    longint sa, sb, r, mx, mn;
    longint unsigned mask;
    mask = (64'd1 << w) - 1;
    sa   = ai[w-1] ? longint'(ai) - (longint'(1) << w) : longint'(ai);
    sb   = bi[w-1] ? longint'(bi) - (longint'(1) << w) : longint'(bi);
    r    = mi ? sa - sb : sa + sb;
    mx   = (longint'(1) << (w - 1)) - 1;
    mn   = -(longint'(1) << (w - 1));
    ev   = (r > mx) || (r < mn);
    ec   = mi ? (ai >= bi) : (((ai + bi) >> w) != 0);
    if (si && ev) es = (r > mx) ? $unsigned(mx) : ($unsigned(mn) & mask);
    else          es = $unsigned(r) & mask;
  endfunction

  task automatic do_op(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                       input logic mi, input logic si, input logic [7:0] es,
                       input logic ec, input logic ev);
    int lat;
    @(negedge clk);
    a = ai; b = bi; m = mi; sat = si; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); m = 1'($urandom); sat = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!done && lat < 20);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_s"}, s, es);
    check({tag, "_c"}, c, ec);
    check({tag, "_v"}, v, ev);
  endtask

  task automatic rand_op();
    longint unsigned ra, rb, es;
    bit rm, rs, ec, ev;
    ra = longint'($urandom_range(255)); rb = longint'($urandom_range(255));
    rm = 1'($urandom); rs = 1'($urandom);
    model(8, ra, rb, rm, rs, es, ec, ev);
    do_op("rnd", 8'(ra), 8'(rb), rm, rs, 8'(es), ec, ev);
  endtask

  // Other parameterisations run concurrently, each with its own stimulus.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int unsigned GW = (g == 1) ? 16 : 8;
    localparam int unsigned GK = (g == 0) ? 1 : 8;
    localparam int unsigned GN = GW / GK;

    logic          rst_s, start_s, m_s, sat_s, ready_s, busy_s, done_s, c_s, v_s;
    logic [GW-1:0] a_s, b_s, s_s;
    bit            fin = 1'b0;

    addsub_chunked #(.W(GW), .K(GK)) u_dut (
      .clk(clk), .rst(rst_s), .start(start_s), .A(a_s), .B(b_s), .M(m_s), .SAT(sat_s),
      .ready(ready_s), .busy(busy_s), .done(done_s), .S(s_s), .C(c_s), .V(v_s)
    );

    initial begin
      rst_s = 1'b1; start_s = 1'b0; a_s = '0; b_s = '0; m_s = 1'b0; sat_s = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_s = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        longint unsigned ra, rb, es;
        bit rm, rs, ec, ev;
        int lat;
        ra = longint'($urandom) & ((64'd1 << GW) - 1);
        rb = longint'($urandom) & ((64'd1 << GW) - 1);
        rm = 1'($urandom); rs = 1'($urandom);
        model(GW, ra, rb, rm, rs, es, ec, ev);
        a_s = GW'(ra); b_s = GW'(rb); m_s = rm; sat_s = rs; start_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0;
        a_s = GW'($urandom); b_s = GW'($urandom);
        lat = 0;
        do begin
          @(posedge clk); lat++;
          @(negedge clk);
        end while (!done_s && lat < int'(3 * GN + 5));
        check($sformatf("sw%0d_lat", g), lat, GN);
        check($sformatf("sw%0d_s", g), s_s, es);
        check($sformatf("sw%0d_c", g), c_s, ec);
        check($sformatf("sw%0d_v", g), v_s, ev);
      end
      fin = 1'b1;
    end
  end

  logic [9:0] exp_q[$];

  initial begin
    longint unsigned es;
    bit ec, ev;
    int cyc, last_done, guard;
    logic seen_done;

    // Reset overrides a concurrent start.
    rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22; m = 1'b0; sat = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_s", s, 8'h00);
    check("rst_cv", {c, v}, 2'b00);
    rst = 1'b0; start = 1'b0;

    do_op("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op("sat_pos", 8'h7F, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    do_op("sat_neg", 8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1);
    do_op("sub_brw", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    do_op("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // start during RUN is ignored; result then holds in IDLE.
    @(negedge clk);
    a = 8'h12; b = 8'h34; m = 1'b0; sat = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("run_busy", busy, 1'b1);
    check("run_ready", ready, 1'b0);
    a = 8'hF0; b = 8'h0F; m = 1'b1; sat = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ign_done", done, 1'b1);
    check("ign_s", s, 8'h46);
    @(posedge clk);
    @(negedge clk);
    check("hold_done", done, 1'b0);
    check("hold_s", s, 8'h46);

    for (int i = 0; i < 150; i++) rand_op();

    // start held high: one accept every 3 edges, each result from its own operands.
    @(negedge clk);
    cyc = 0; last_done = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        check("b2b_res", {c, v, s}, exp_q.size() > 0 ? exp_q.pop_front() : 10'h3FF);
        if (last_done >= 0) check("b2b_gap", cyc - last_done, 3);
        last_done = cyc;
      end
      a = 8'($urandom); b = 8'($urandom); m = 1'($urandom); sat = 1'($urandom);
      start = 1'b1;
      if (ready) begin
        model(8, longint'(a), longint'(b), m, sat, es, ec, ev);
        exp_q.push_back({ec, ev, 8'(es)});
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) check("b2b_tail", {c, v, s}, exp_q.size() > 0 ? exp_q.pop_front() : 10'h3FF);
      @(negedge clk);
    end
    check("b2b_drain", exp_q.size(), 0);

    // Reset on the first RUN edge aborts the operation without a done pulse.
    do_op("pre_rst", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h7F; b = 8'h01; m = 1'b0; sat = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_s", s, 8'h00);
    check("abort_cv", {c, v}, 2'b00);
    seen_done = done;
    repeat (4) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    check("abort_nodone", seen_done, 1'b0);
    do_op("post_rst", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    guard = 0;
    while (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin) && guard < 60000) begin
      @(posedge clk);
      guard++;
    end
    check("sweep_fin", {g_sweep[0].fin, g_sweep[1].fin, g_sweep[2].fin}, 3'b111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
